// File: rtl/cmem_pkg.sv
// rtl/cmem_pkg.sv - shared cmem geometry, strobe polarity and loader state encoding
package cmem_pkg;

  localparam int CMEM_AW    = 8;
  localparam int CMEM_DW    = 20;
  localparam int CMEM_DEPTH = 256;

  // cmem CEN/WEN are active low
  localparam logic CMEM_ON  = 1'b0;
  localparam logic CMEM_OFF = 1'b1;

  typedef enum logic [1:0] {
    CMEM_LD_IDLE = 2'd0,
    CMEM_LD_LOAD = 2'd1,
    CMEM_LD_DONE = 2'd2
  } cmem_ld_state_e;

endpackage

// File: rtl/cmem_loader.sv
// rtl/cmem_loader.sv - stream-to-cmem write sequencer; optional CMEM_LOADER_CKSUM_EN adds cksum output
module cmem_loader
  import cmem_pkg::*;
#(
  parameter int AW    = CMEM_AW,
  parameter int DW    = CMEM_DW,
  parameter int DEPTH = CMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] CADDR,
  output logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
`ifdef CMEM_LOADER_CKSUM_EN
  output logic [DW-1:0] cksum,
`endif
  output logic          wrapped
);

  localparam logic [1:0] S_IDLE = CMEM_LD_IDLE;
  localparam logic [1:0] S_LOAD = CMEM_LD_LOAD;
  localparam logic [1:0] S_DONE = CMEM_LD_DONE;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;
  logic          hs;

  // Accept only while loading; abort blocks the word offered in the same cycle
  always_comb begin
    in_ready = (state == S_LOAD) & ~abort;
    hs       = in_valid & in_ready;
    busy     = (state != S_IDLE);
  end

  // FSM, address pointer, remaining count and registered cmem write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      rem     <= '0;
      CEN     <= CMEM_OFF;
      WEN     <= CMEM_OFF;
      CADDR   <= '0;
      D       <= '0;
      done    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      done <= 1'b0;
      CEN  <= CMEM_OFF;
      WEN  <= CMEM_OFF;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr     <= base_addr;
            rem     <= count;
            wrapped <= 1'b0;
            state   <= (count != '0) ? S_LOAD : S_DONE;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (hs) begin
            CEN   <= CMEM_ON;
            WEN   <= CMEM_ON;
            CADDR <= ptr;
            D     <= in_data;
            ptr   <= ptr + AW'(1);
            rem   <= rem - (AW+1)'(1);
            // only a wrap if another word follows the write to the top address
            if ((ptr == PTR_LAST) && (rem > (AW+1)'(1))) begin
              wrapped <= 1'b1;
            end
            if (rem == (AW+1)'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // final write is being committed this cycle; report on the next
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CMEM_LOADER_CKSUM_EN
  // Running sum of accepted words, restarted on each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      cksum <= '0;
    end else if (hs) begin
      cksum <= cksum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_cmem_loader.sv
// tb/tb_cmem_loader.sv - directed self-checking bench for cmem_loader with a behavioural cmem
module tb_cmem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  count = '0;
  logic        abort = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        CEN, WEN;
  logic [7:0]  CADDR;
  logic [19:0] D;
  logic        busy, done, wrapped;
`ifdef CMEM_LOADER_CKSUM_EN
  logic [19:0] cksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int both_err = 0;
  int wen_err = 0;

  logic [19:0] mem   [0:255];
  logic [19:0] wdata [0:255];
  logic [7:0]  sq_addr [$];
  int          sq_cyc  [$];
  logic        sq_wrap [$];

  cmem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .CEN(CEN), .WEN(WEN), .CADDR(CADDR), .D(D),
    .busy(busy), .done(done),
`ifdef CMEM_LOADER_CKSUM_EN
    .cksum(cksum),
`endif
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural cmem: a strobe visible during a cycle commits at its closing edge
  always @(posedge clk) begin
    if (rst_n && !CEN && !WEN) mem[CADDR] <= D;
  end

  always @(negedge clk) begin
    if (rst_n && !CEN) begin
      sq_addr.push_back(CADDR);
      sq_cyc.push_back(cyc);
      sq_wrap.push_back(wrapped);
      if (WEN) wen_err++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done && busy) both_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_burst(input logic [7:0] b, input logic [8:0] n, input logic [31:0] vpat,
                          input int abort_k, output int start_cyc, output logic abort_rdy);
    int k;
    int c;
    logic hs;
    sq_addr.delete();
    sq_cyc.delete();
    sq_wrap.delete();
    done_cnt  = 0;
    abort_rdy = 1'b1;
    base_addr = b;
    count     = n;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    c = 0;
    while (busy && c < 2000) begin
      in_valid = vpat[c % 32];
      in_data  = wdata[k % 256];
      abort    = (abort_k >= 0) && (k == abort_k);
      @(negedge clk);
      if (abort) abort_rdy = in_ready;
      hs = in_valid & in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      c++;
      if (abort) begin
        abort    = 1'b0;
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    check("loop_bound", 32'(c < 2000), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  int   sc;
  logic ar;
  int   bad;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset state
    #12;
    @(negedge clk);
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_caddr", CADDR, 0);
    check("rst_d", D, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // full memory, back to back
    for (int i = 0; i < 256; i++) wdata[i] = 20'(i + 1000);
    do_burst(8'd0, 9'd256, 32'hFFFF_FFFF, -1, sc, ar);
    check("full_strobes", sq_addr.size(), 256);
    bad = 0;
    for (int i = 0; i < 256 && i < sq_addr.size(); i++) if (sq_addr[i] != 8'(i)) bad++;
    check("full_addr_seq", bad, 0);
    check("full_b2b", sq_cyc[255] - sq_cyc[0], 255);
    check("full_done_lat", done_cyc - sq_cyc[255], 1);
    check("full_done_cnt", done_cnt, 1);
    check("full_wrapped", wrapped, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 20'(i + 1000)) bad++;
    check("full_mem", bad, 0);
    check("full_mem_ff", mem[255], 20'd1255);

    // wrap across the top address
    for (int i = 0; i < 10; i++) wdata[i] = 20'(i + 2000);
    do_burst(8'd250, 9'd10, 32'hFFFF_FFFF, -1, sc, ar);
    check("wrap_strobes", sq_addr.size(), 10);
    bad = 0;
    for (int i = 0; i < 10 && i < sq_addr.size(); i++) if (sq_addr[i] != 8'(250 + i)) bad++;
    check("wrap_addr_seq", bad, 0);
    check("wrap_flag_254", sq_wrap[4], 0);
    check("wrap_flag_at0", sq_wrap[6], 1);
    check("wrap_sticky", wrapped, 1);
    check("wrap_mem250", mem[250], 20'd2000);
    check("wrap_mem3", mem[3], 20'd2009);
    check("wrap_mem4_kept", mem[4], 20'd1004);

    // bubbles on in_valid: 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++) wdata[i] = 20'(i + 500);
    do_burst(8'h10, 9'd4, 32'hFFFF_FFD9, -1, sc, ar);
    check("bub_strobes", sq_addr.size(), 4);
    bad = 0;
    for (int i = 0; i < 4 && i < sq_addr.size(); i++) if (sq_addr[i] != 8'(8'h10 + i)) bad++;
    check("bub_addr_seq", bad, 0);
    check("bub_gap", sq_cyc[1] - sq_cyc[0], 3);
    check("bub_mem13", mem[8'h13], 20'd503);
    check("bub_wrap_clr", wrapped, 0);

    // empty burst
    do_burst(8'h30, 9'd0, 32'hFFFF_FFFF, -1, sc, ar);
    check("zero_strobes", sq_addr.size(), 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_lat", done_cyc - sc, 2);

    // abort offered alongside the 6th word
    for (int i = 0; i < 10; i++) wdata[i] = 20'(i + 4000);
    do_burst(8'h40, 9'd10, 32'hFFFF_FFFF, 5, sc, ar);
    check("abort_ready", ar, 0);
    check("abort_strobes", sq_addr.size(), 5);
    check("abort_no_done", done_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_mem45_kept", mem[8'h45], 20'd1069);

    // reset mid-burst drops the pending write at once
    for (int i = 0; i < 10; i++) wdata[i] = 20'(i + 3000);
    base_addr = 8'h20;
    count     = 9'd10;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = wdata[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rstmid_pre_cen", CEN, 0);
    check("rstmid_pre_addr", CADDR, 8'h22);
    rst_n = 1'b0;
    #1;
    check("rstmid_cen", CEN, 1);
    check("rstmid_wen", WEN, 1);
    check("rstmid_busy", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_mem21", mem[8'h21], 20'd3001);
    check("rstmid_mem22_kept", mem[8'h22], 20'd1034);

`ifdef CMEM_LOADER_CKSUM_EN
    wdata[0] = 20'hFFFFF;
    wdata[1] = 20'h00002;
    wdata[2] = 20'h00010;
    do_burst(8'h80, 9'd3, 32'hFFFF_FFFF, -1, sc, ar);
    check("cksum_done_cnt", done_cnt, 1);
    check("cksum_val", cksum, 20'h00011);
`endif

    check("done_busy_excl", both_err, 0);
    check("cen_wen_pair", wen_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmem_loader.md
Name: cmem_loader

Overview:
- Upstream write-side sequencer for the 256 x 20-bit coefficient memory (cmem).
- Accepts a burst of coefficients over a valid/ready stream and drives cmem's active-low CEN/WEN, CADDR and D write port, one word per cycle.
- Writes consecutive addresses starting at a programmed base.
- Signals completion only after the last write is committed.

Parameters:
- AW, 8, address width (cmem CADDR width)
- DW, 20, coefficient data width (cmem D width)
- DEPTH, 256, cmem word count (2**AW)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin burst; sampled only in IDLE
- base_addr  in  AW  first cmem address of burst
- count  in  AW+1  words in burst, 0..256
- abort  in  1  terminate burst in progress
- in_data  in  DW  coefficient word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- CEN  out  1  cmem chip enable, active low
- WEN  out  1  cmem write enable, active low
- CADDR  out  AW  cmem write address
- D  out  DW  cmem write data
- busy  out  1  burst in progress (LOAD or DONE)
- done  out  1  one-cycle pulse, burst fully committed
- wrapped  out  1  sticky; burst crossed address 255 -> 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, CEN=1, WEN=1, CADDR=0, D=0, busy=0, done=0, wrapped=0, internal pointer/remaining=0. Reset mid-burst drops all pending writes immediately.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches base_addr into ptr and count into rem, clears wrapped.
  - Goes to LOAD if count!=0, else DONE.
- LOAD:
  - in_ready = (state==LOAD) & ~abort, combinational.
  - Handshake (in_valid & in_ready) at edge E: CEN=0, WEN=0, CADDR=ptr, D=in_data, registered and held during cycle E..E+1. cmem commits at E+1. ptr<=ptr+1 mod 256; rem<=rem-1.
  - If ptr==255 at a handshake and rem>1: wrapped<=1.
  - Handshake with rem==1 -> DONE.
  - No handshake: CEN=WEN=1; CADDR and D hold.
  - abort=1 -> IDLE next edge. Any simultaneous in_valid is not accepted. CEN=WEN=1, no done.
- DONE:
  - Lasts one cycle; CEN/WEN show the final write (or 1 if count==0).
  - Next edge -> IDLE, done=1 for exactly that one cycle, CEN=WEN=1.
  - abort ignored.
- Throughput 1 word/cycle; latency accept -> commit = 1 edge.
- busy=1 in LOAD and DONE; done and busy never both 1.
- start outside IDLE is ignored.
- in_data width exact; no truncation or extension.

Optional Feature:
CMEM_LOADER_CKSUM_EN
- Defined:
  - Adds output port cksum (DW bits), reset 0, cleared on accepted start.
  - Adds in_data of every accepted word, modulo 2**DW.
  - Stable and valid from the cycle done pulses until the next start.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package cmem_pkg:
  - CMEM_AW=8, CMEM_DW=20, CMEM_DEPTH=256
  - CMEM_ON=1'b0, CMEM_OFF=1'b1
  - loader state enum {IDLE, LOAD, DONE}
- Reused by cmem and its read-side consumers.
- No sub-module. Pointer, remaining counter and FSM fit in one module.

Test Plan:
- base=0, count=256, in_valid held 1, in_data=k+1000 for word k -> 256 back-to-back strobes, CADDR 0..255, done one cycle after last strobe; cmem A0=n reads Q0=n+1000; wrapped=0.
- base=250, count=10 -> CADDR 250..255, 0..3; wrapped=1 at the 0 write; cmem[4] unchanged.
- in_valid pattern 1,0,0,1,1,0,1 with count=4 -> CEN low exactly 4 cycles; CADDR base..base+3 with no duplicates or skips; CEN high in bubbles.
- count=0 -> IDLE, DONE, IDLE; done pulses 2 cycles after start; CEN never low.
- abort asserted with in_valid=1 on 6th word -> exactly 5 writes, in_ready=0 that cycle, no done, busy=0 next cycle. Separately, rst_n low mid-burst -> CEN=WEN=1 immediately.
- CMEM_LOADER_CKSUM_EN defined, count=3, data 0xFFFFF, 0x00002, 0x00010 -> cksum=0x00011 at done.
